lrwait_qnode_multi: RTL and testbench

- Parametrised successor to the single-reservation LRWait queue node. Sits between a Snitch core's TCDM request/response port and the tile interconnect.
- Tracks up to NumSlots concurrent LR reservations, each to a distinct address. For each slot it records the successor metadata delivered by SuccUpdate responses.
- After the core's matching SC has been accepted, it injects a WakeUp request (qlrwait=1) carrying that metadata.
- SuccUpdates are absorbed; all other traffic passes through.

---
 rtl/lrwait_qnode_multi.sv | 206 ++++++++++++++++++++
 tb/tb_lrwait_qnode_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lrwait_qnode_multi.sv
// Multi-reservation LRWait queue node between a Snitch TCDM port and the tile interconnect.
// Optional error detection is built when LRWAIT_QNODE_ERR_EN is defined.
module lrwait_qnode_multi #(
  parameter int unsigned NumSlots  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaWidth = 8,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] snitch_qaddr_i,
  input  logic                 snitch_qwrite_i,
  input  logic [3:0]           snitch_qamo_i,
  input  logic [DataWidth-1:0] snitch_qdata_i,
  input  logic [DataWidth-1:0] snitch_qstrb_i,
  input  logic [IdWidth-1:0]   snitch_qid_i,
  input  logic                 snitch_qvalid_i,
  output logic                 snitch_qready_o,
  output logic [DataWidth-1:0] snitch_pdata_o,
  output logic                 snitch_perror_o,
  output logic [IdWidth-1:0]   snitch_pid_o,
  output logic                 snitch_pvalid_o,
  input  logic                 snitch_pready_i,
  output logic [AddrWidth-1:0] tile_qaddr_o,
  output logic                 tile_qwrite_o,
  output logic [3:0]           tile_qamo_o,
  output logic [DataWidth-1:0] tile_qdata_o,
  output logic [DataWidth-1:0] tile_qstrb_o,
  output logic [IdWidth-1:0]   tile_qid_o,
  output logic                 tile_qlrwait_o,
  output logic                 tile_qvalid_o,
  input  logic                 tile_qready_i,
  input  logic [DataWidth-1:0] tile_pdata_i,
  input  logic                 tile_perror_i,
  input  logic [IdWidth-1:0]   tile_pid_i,
  input  logic                 tile_plrwait_i,
  input  logic                 tile_pvalid_i,
  output logic                 tile_pready_o,
  output logic                 error_o
);

  // Handshake: a transfer happens in the cycle where valid and ready are both high;
  // once valid is raised, the payload holds steady until that cycle.
  localparam logic [3:0] AmoLr = 4'hA;
  localparam logic [3:0] AmoSc = 4'hB;
  localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  typedef enum logic [2:0] {Idle, WaitLR, WaitSC, InQueue, SendWakeUp} slot_state_e;

  slot_state_e          state_q   [NumSlots];
  logic [AddrWidth-1:0] addr_q    [NumSlots];
  logic [IdWidth-1:0]   id_q      [NumSlots];
  logic [MetaWidth-1:0] meta_q    [NumSlots];
  logic [NumSlots-1:0]  sc_sent_q;
  logic                 inj_lock_q, stall_q;
  logic [SlotIdxW-1:0]  inj_idx_q;

  logic [NumSlots-1:0] addr_hit, sc_hit, id_hit, idle_vec, wake_vec;
  logic [NumSlots-1:0] alloc_sel, su_sel, wake_first;
  logic [SlotIdxW-1:0] wake_idx, inj_idx;
  logic lr_req, sc_req, lr_block, injecting;
  logic req_fire, lr_fire, sc_fire, su_fire, rsp_fire, inj_fire;

  function automatic logic [NumSlots-1:0] lowest(input logic [NumSlots-1:0] v);
    return v & (~v + NumSlots'(1));
  endfunction

  always_comb begin
    addr_hit = '0;
    sc_hit   = '0;
    id_hit   = '0;
    idle_vec = '0;
    wake_vec = '0;
    for (int i = 0; i < NumSlots; i++) begin
      idle_vec[i] = (state_q[i] == Idle);
      wake_vec[i] = (state_q[i] == SendWakeUp);
      addr_hit[i] = !idle_vec[i] && (addr_q[i] == snitch_qaddr_i);
      sc_hit[i]   = addr_hit[i] && (state_q[i] == WaitSC || state_q[i] == InQueue);
      id_hit[i]   = !idle_vec[i] && (id_q[i] == tile_pid_i);
    end
    alloc_sel  = lowest(idle_vec);
    su_sel     = lowest(id_hit);
    wake_first = lowest(wake_vec);
    wake_idx   = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (wake_first[i]) wake_idx = SlotIdxW'(i);
    end
  end

  assign lr_req    = (snitch_qamo_i == AmoLr);
  assign sc_req    = (snitch_qamo_i == AmoSc);
  assign lr_block  = lr_req && !(|addr_hit) && !(|idle_vec);
  // A locked WakeUp keeps its slot until accepted, even if a lower slot becomes ready.
  assign injecting = !rst_i && (inj_lock_q || ((|wake_vec) && !stall_q));
  assign inj_idx   = inj_lock_q ? inj_idx_q : wake_idx;

  assign snitch_qready_o = !rst_i && !injecting && !lr_block && tile_qready_i;
  assign req_fire  = snitch_qvalid_i && snitch_qready_o;
  assign lr_fire   = req_fire && lr_req;
  assign sc_fire   = req_fire && sc_req;
  assign su_fire   = tile_pvalid_i && tile_plrwait_i;
  assign rsp_fire  = tile_pvalid_i && !tile_plrwait_i && snitch_pready_i;
  assign inj_fire  = injecting && tile_qready_i;

  always_comb begin
    tile_qaddr_o   = snitch_qaddr_i;
    tile_qwrite_o  = snitch_qwrite_i;
    tile_qamo_o    = snitch_qamo_i;
    tile_qdata_o   = snitch_qdata_i;
    tile_qstrb_o   = snitch_qstrb_i;
    tile_qid_o     = snitch_qid_i;
    tile_qlrwait_o = 1'b0;
    tile_qvalid_o  = !rst_i && snitch_qvalid_i && !lr_block;
    if (injecting) begin
      tile_qaddr_o   = addr_q[inj_idx];
      tile_qwrite_o  = 1'b0;
      tile_qamo_o    = AmoLr;
      tile_qdata_o   = DataWidth'(meta_q[inj_idx]);
      tile_qid_o     = id_q[inj_idx];
      tile_qlrwait_o = 1'b1;
      tile_qvalid_o  = 1'b1;
    end
  end

  assign snitch_pdata_o  = tile_pdata_i;
  assign snitch_perror_o = tile_perror_i;
  assign snitch_pid_o    = tile_pid_i;
  assign snitch_pvalid_o = !rst_i && tile_pvalid_i && !tile_plrwait_i;
  assign tile_pready_o   = tile_plrwait_i ? 1'b1 : snitch_pready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= Idle;
        addr_q[i]  <= '0;
        id_q[i]    <= '0;
        meta_q[i]  <= '0;
      end
      sc_sent_q  <= '0;
      inj_lock_q <= 1'b0;
      inj_idx_q  <= '0;
      stall_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        // Nested LR or accepted SC retargets the slot to the newest core id.
        if (!idle_vec[i] && (lr_fire || sc_fire) && addr_hit[i]) id_q[i] <= snitch_qid_i;
        if (su_fire && su_sel[i] && state_q[i] != SendWakeUp) meta_q[i] <= tile_pdata_i[MetaWidth-1:0];
        case (state_q[i])
          Idle: if (lr_fire && !(|addr_hit) && alloc_sel[i]) begin
            addr_q[i]    <= snitch_qaddr_i;
            id_q[i]      <= snitch_qid_i;
            sc_sent_q[i] <= 1'b0;
            state_q[i]   <= WaitLR;
          end
          WaitLR: begin
            if (su_fire && su_sel[i]) state_q[i] <= InQueue;
            else if (rsp_fire && id_hit[i]) state_q[i] <= WaitSC;
          end
          WaitSC: begin
            if (su_fire && su_sel[i])
              state_q[i] <= (sc_sent_q[i] || (sc_fire && sc_hit[i])) ? SendWakeUp : InQueue;
            else if (sc_fire && sc_hit[i]) sc_sent_q[i] <= 1'b1;
            else if (sc_sent_q[i] && rsp_fire && id_hit[i]) state_q[i] <= Idle;
          end
          InQueue: if (sc_fire && sc_hit[i]) state_q[i] <= SendWakeUp;
          SendWakeUp: if (inj_fire && inj_idx == SlotIdxW'(i)) state_q[i] <= Idle;
          default: state_q[i] <= Idle;
        endcase
      end
      if (inj_fire) begin
        inj_lock_q <= 1'b0;
      end else if (injecting) begin
        inj_lock_q <= 1'b1;
        inj_idx_q  <= inj_idx;
      end
      stall_q <= snitch_qvalid_i && tile_qvalid_o && !tile_qready_i && !injecting;
    end
  end

`ifdef LRWAIT_QNODE_ERR_EN
  logic        err_q;
  logic [10:0] block_cnt_q;
  logic        lr_waiting;

  assign lr_waiting = snitch_qvalid_i && lr_block && !injecting;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      block_cnt_q <= '0;
    end else begin
      if (lr_waiting) block_cnt_q <= (block_cnt_q == 11'd1024) ? block_cnt_q : block_cnt_q + 11'd1;
      else            block_cnt_q <= '0;
      // block_cnt_q counts earlier blocked cycles, so 1024 here means the 1025th in a row.
      if ((su_fire && !(|id_hit)) || (sc_fire && !(|addr_hit)) ||
          (lr_waiting && block_cnt_q == 11'd1024))
        err_q <= 1'b1;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_lrwait_qnode_multi.sv
// Directed bench for lrwait_qnode_multi: LR/SC/SuccUpdate sequences with hand-computed WakeUps.
module tb_lrwait_qnode_multi;

`ifdef LRWAIT_QNODE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] snitch_qaddr_i, snitch_qdata_i, snitch_qstrb_i;
  logic        snitch_qwrite_i, snitch_qvalid_i, snitch_qready_o;
  logic [3:0]  snitch_qamo_i, snitch_qid_i;
  logic [31:0] snitch_pdata_o;
  logic        snitch_perror_o, snitch_pvalid_o, snitch_pready_i;
  logic [3:0]  snitch_pid_o;
  logic [31:0] tile_qaddr_o, tile_qdata_o, tile_qstrb_o;
  logic        tile_qwrite_o, tile_qlrwait_o, tile_qvalid_o, tile_qready_i;
  logic [3:0]  tile_qamo_o, tile_qid_o;
  logic [31:0] tile_pdata_i;
  logic        tile_perror_i, tile_plrwait_i, tile_pvalid_i, tile_pready_o;
  logic [3:0]  tile_pid_i;
  logic        error_o;

  int n_cmp = 0;
  int n_err = 0;
  int wake_seen = 0;
  int exp_wakes = 0;

  lrwait_qnode_multi dut (
    .clk_i(clk), .rst_i(rst_i),
    .snitch_qaddr_i(snitch_qaddr_i), .snitch_qwrite_i(snitch_qwrite_i),
    .snitch_qamo_i(snitch_qamo_i), .snitch_qdata_i(snitch_qdata_i),
    .snitch_qstrb_i(snitch_qstrb_i), .snitch_qid_i(snitch_qid_i),
    .snitch_qvalid_i(snitch_qvalid_i), .snitch_qready_o(snitch_qready_o),
    .snitch_pdata_o(snitch_pdata_o), .snitch_perror_o(snitch_perror_o),
    .snitch_pid_o(snitch_pid_o), .snitch_pvalid_o(snitch_pvalid_o),
    .snitch_pready_i(snitch_pready_i),
    .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o),
    .tile_qamo_o(tile_qamo_o), .tile_qdata_o(tile_qdata_o),
    .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
    .tile_qlrwait_o(tile_qlrwait_o), .tile_qvalid_o(tile_qvalid_o),
    .tile_qready_i(tile_qready_i),
    .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i),
    .tile_pid_i(tile_pid_i), .tile_plrwait_i(tile_plrwait_i),
    .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o),
    .error_o(error_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (tile_qvalid_o && tile_qlrwait_o && tile_qready_i) wake_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    snitch_qaddr_i = '0; snitch_qwrite_i = 1'b0; snitch_qamo_i = '0;
    snitch_qdata_i = '0; snitch_qstrb_i = '0; snitch_qid_i = '0;
    snitch_qvalid_i = 1'b0; snitch_pready_i = 1'b1;
    tile_qready_i = 1'b1; tile_pdata_i = '0; tile_perror_i = 1'b0;
    tile_pid_i = '0; tile_plrwait_i = 1'b0; tile_pvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    snitch_qvalid_i = 1'b1;
    snitch_qamo_i = 4'hA;
    repeat (2) begin
      @(negedge clk);
      check("rst_qvalid", tile_qvalid_o, 0);
      check("rst_lrwait", tile_qlrwait_o, 0);
      check("rst_pvalid", snitch_pvalid_o, 0);
      check("rst_error", error_o, 0);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle_inputs();
  endtask

  // Drive one core request and wait (bounded) for its handshake.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] amo, input logic [3:0] id);
    bit ok = 1'b0;
    snitch_qaddr_i = addr; snitch_qamo_i = amo; snitch_qid_i = id;
    snitch_qwrite_i = 1'b0; snitch_qdata_i = '0; snitch_qvalid_i = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (snitch_qready_o) ok = 1'b1;
      else tick();
    end
    check("req_ready", ok, 1);
    check("req_pass_addr", tile_qaddr_o, addr);
    check("req_pass_lrwait", tile_qlrwait_o, 0);
    tick();
    snitch_qvalid_i = 1'b0;
  endtask

  task automatic do_rsp(input logic [3:0] pid, input logic [31:0] data, input logic su);
    tile_pid_i = pid; tile_pdata_i = data; tile_plrwait_i = su; tile_pvalid_i = 1'b1;
    @(negedge clk);
    check("rsp_fwd", snitch_pvalid_o, !su);
    check("rsp_pready", tile_pready_o, 1);
    tick();
    tile_pvalid_i = 1'b0; tile_plrwait_i = 1'b0;
  endtask

  task automatic expect_wake(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] id);
    @(negedge clk);
    check("wake_valid", tile_qvalid_o, 1);
    check("wake_lrwait", tile_qlrwait_o, 1);
    check("wake_addr", tile_qaddr_o, addr);
    check("wake_data", tile_qdata_o, data);
    check("wake_id", tile_qid_o, id);
    check("wake_amo", tile_qamo_o, 4'hA);
    check("wake_write", tile_qwrite_o, 0);
    check("wake_core_blocked", snitch_qready_o, 0);
    exp_wakes++;
    tick();
    @(negedge clk);
    check("wake_done_lrwait", tile_qlrwait_o, 0);
    check("wake_done_valid", tile_qvalid_o, 0);
    check("wake_count", wake_seen, exp_wakes);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Basic LR / SuccUpdate / SC / WakeUp
    do_req(32'h100, 4'hA, 4'd3);
    do_rsp(4'd3, 32'h0, 1'b0);
    do_rsp(4'd3, 32'h2A, 1'b1);
    do_req(32'h100, 4'hB, 4'd5);
    expect_wake(32'h100, 32'h2A, 4'd5);

    // SC completes without SuccUpdate: no WakeUp
    do_req(32'h100, 4'hA, 4'd1);
    do_rsp(4'd1, 32'h0, 1'b0);
    do_req(32'h100, 4'hB, 4'd2);
    do_rsp(4'd2, 32'h0, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    check("nowake_valid", tile_qvalid_o, 0);
    check("nowake_count", wake_seen, exp_wakes);

    // Both slots held: third LR stalls until the SC response frees slot 0
    do_req(32'h100, 4'hA, 4'd1);
    do_rsp(4'd1, 32'h0, 1'b0);
    do_req(32'h100, 4'hB, 4'd4);
    do_req(32'h200, 4'hA, 4'd2);
    snitch_qaddr_i = 32'h300; snitch_qamo_i = 4'hA; snitch_qid_i = 4'd3; snitch_qvalid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", snitch_qready_o, 0);
      check("full_tvalid", tile_qvalid_o, 0);
      tick();
    end
    tile_pid_i = 4'd4; tile_plrwait_i = 1'b0; tile_pvalid_i = 1'b1;
    @(negedge clk);
    check("full_ready_sc_rsp", snitch_qready_o, 0);
    check("full_sc_rsp_fwd", snitch_pvalid_o, 1);
    tick();
    tile_pvalid_i = 1'b0;
    @(negedge clk);
    check("freed_ready", snitch_qready_o, 1);
    check("freed_addr", tile_qaddr_o, 32'h300);
    tick();
    snitch_qvalid_i = 1'b0;
    do_reset();

    // SuccUpdate after SC already sent
    do_req(32'h100, 4'hA, 4'd1);
    do_rsp(4'd1, 32'h0, 1'b0);
    do_req(32'h100, 4'hB, 4'd6);
    do_rsp(4'd6, 32'h11, 1'b1);
    expect_wake(32'h100, 32'h11, 4'd6);
    do_reset();

    // WakeUp becomes pending while a store is stalled at the tile
    do_req(32'h100, 4'hA, 4'd1);
    do_rsp(4'd1, 32'h0, 1'b0);
    do_req(32'h100, 4'hB, 4'd7);
    tile_qready_i = 1'b0;
    snitch_qaddr_i = 32'h400; snitch_qwrite_i = 1'b1; snitch_qamo_i = 4'h0;
    snitch_qdata_i = 32'hDEADBEEF; snitch_qstrb_i = 32'hF; snitch_qid_i = 4'd9; snitch_qvalid_i = 1'b1;
    tile_pid_i = 4'd7; tile_pdata_i = 32'h33; tile_plrwait_i = 1'b1; tile_pvalid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_addr", tile_qaddr_o, 32'h400);
      check("stall_write", tile_qwrite_o, 1);
      check("stall_data", tile_qdata_o, 32'hDEADBEEF);
      check("stall_lrwait", tile_qlrwait_o, 0);
      check("stall_su_hidden", snitch_pvalid_o, 0);
      tick();
      tile_pvalid_i = 1'b0; tile_plrwait_i = 1'b0;
    end
    tile_qready_i = 1'b1;
    @(negedge clk);
    check("store_ready", snitch_qready_o, 1);
    check("store_lrwait", tile_qlrwait_o, 0);
    check("store_id", tile_qid_o, 4'd9);
    check("store_strb", tile_qstrb_o, 32'hF);
    tick();
    snitch_qvalid_i = 1'b0; snitch_qwrite_i = 1'b0;
    expect_wake(32'h100, 32'h33, 4'd7);

    // Reset with a WakeUp pending discards it
    do_req(32'h100, 4'hA, 4'd1);
    do_rsp(4'd1, 32'h0, 1'b0);
    do_rsp(4'd1, 32'h5, 1'b1);
    do_req(32'h100, 4'hB, 4'd2);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_valid", tile_qvalid_o, 0);
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("midrst_nowake_valid", tile_qvalid_o, 0);
    check("midrst_nowake_count", wake_seen, exp_wakes);

    // Unmatched SuccUpdate
    do_rsp(4'd7, 32'h99, 1'b1);
    @(negedge clk);
    check("err_set", error_o, ErrEn);
    repeat (3) tick();
    @(negedge clk);
    check("err_sticky", error_o, ErrEn);
    do_reset();
    @(negedge clk);
    check("err_cleared", error_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
